// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer slice.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package reset_sequencer_pkg;

  localparam int CycleCountWidth = 32;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    GAP    = 2'd1,
    RUN    = 2'd2,
    ASSERT = 2'd3
  } state_e;

  // Saturating increment: sticks at all-ones instead of wrapping back to zero.
  function automatic logic [CycleCountWidth-1:0] sat_inc(input logic [CycleCountWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its controller.
// Latency: n/a (wiring only).
// Backpressure: none; hold is the only throttle and it only gates sequence start.
interface reset_sequencer_if
  import reset_sequencer_pkg::*;
#(
  parameter int NumDomains = 4
) ();

  logic                       sw_rst_req;
  logic                       hold;
  logic [NumDomains-1:0]      domain_rst_n;
  logic                       ready;
  logic                       busy;
  logic [CycleCountWidth-1:0] cycle_count;
  logic                       limit_hit;

  // Controller side: issues requests, observes reset/status outputs.
  modport master (
    output sw_rst_req, hold,
    input  domain_rst_n, ready, busy, cycle_count, limit_hit
  );

  // Sequencer side.
  modport slave (
    input  sw_rst_req, hold,
    output domain_rst_n, ready, busy, cycle_count, limit_hit
  );

endinterface

// File: rtl/reset_synchronizer.sv
// Async-assert / sync-deassert reset synchroniser.
// Latency: deasserts SyncStages posedges after rst_n rises; asserts immediately.
// Backpressure: none.
module reset_synchronizer #(
  parameter int SyncStages = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);

  logic [SyncStages-1:0] chain_q;

  // Clear the chain asynchronously, then shift ones in once rst_n is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SyncStages-2:0], 1'b1};
    end
  end

  assign sync_rst_n = chain_q[SyncStages-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases NumDomains reset domains one by one after a synchronised power-on reset or sw reset.
// Latency: first domain releases ReleaseGap posedges after T0; all outputs are registered.
// Backpressure: hold=1 defers the start of a release sequence; it is ignored once sequencing.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int                         NumDomains    = 4,
  parameter int                         SyncStages    = 2,
  parameter int                         ReleaseGap    = 2,
  parameter int                         SwResetCycles = 4,
  parameter logic [CycleCountWidth-1:0] MaxCycleCount = 32'd1048576
) (
  input  logic               clk,
  input  logic               rst_n,
  reset_sequencer_if.slave   bus
);

  // The single down-counter serves both the release gap and the sw-reset hold window.
  localparam int CntMax = (ReleaseGap > SwResetCycles) ? ReleaseGap : SwResetCycles;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam int IdxW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  // Gap counter is loaded with ReleaseGap-1 so that domain k lands on T0+(k+1)*ReleaseGap.
  localparam logic [CntW-1:0] GapLoad = CntW'(ReleaseGap - 1);
  localparam logic [CntW-1:0] SwLoad  = CntW'(SwResetCycles);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumDomains - 1);

  logic                       sync_rst_n;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [NumDomains-1:0]      rel_q, rel_d;
  logic                       ready_q, ready_d;
  logic                       busy_q, busy_d;
  logic [CycleCountWidth-1:0] count_q, count_d;
  logic                       limit_q, limit_d;
  logic                       por_start;

  reset_synchronizer #(
    .SyncStages (SyncStages)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_rst_n (sync_rst_n)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the gap/assert counter, domain index and release mask.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rel_d   = rel_q;

    unique case (state_q)
      SYNC: begin
        // sw_rst_req is deliberately not looked at here.
        if (sync_rst_n && !bus.hold) begin
          state_d = GAP;
          cnt_d   = GapLoad;
          idx_d   = '0;
        end
      end

      GAP: begin
        if (bus.sw_rst_req) begin
          state_d = ASSERT;
          cnt_d   = SwLoad;
          idx_d   = '0;
          rel_d   = '0;
        end else if (cnt_q == '0) begin
          rel_d[idx_q] = 1'b1;
          cnt_d        = GapLoad;
          if (idx_q == LastIdx) begin
            state_d = RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RUN: begin
        if (bus.sw_rst_req) begin
          state_d = ASSERT;
          cnt_d   = SwLoad;
          idx_d   = '0;
          rel_d   = '0;
        end
      end

      ASSERT: begin
        if (bus.sw_rst_req) begin
          // A repeated request restarts the hold window.
          cnt_d = SwLoad;
        end else if (cnt_q <= CntW'(1)) begin
          // Window expired: this posedge becomes the new T0 unless hold parks us at zero.
          if (!bus.hold) begin
            state_d = GAP;
            cnt_d   = GapLoad;
            idx_d   = '0;
          end else begin
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = SYNC;
      end
    endcase

    // ready rises one posedge after entering RUN; any exit drops it on the same edge.
    ready_d = (state_q == RUN) && (state_d == RUN);
    busy_d  = !ready_d;
  end

  // Cycle counter and sticky limit; a non-zero count means counting has started.
  always_comb begin
    por_start = (state_q == SYNC) && (state_d == GAP);
    count_d   = count_q;
    if (count_q != '0) begin
      count_d = sat_inc(count_q);
    end else if (por_start) begin
      count_d = CycleCountWidth'(1);
    end
    limit_d = limit_q | ((MaxCycleCount != '0) && (count_d == MaxCycleCount));
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      count_q <= '0;
      limit_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rel_q   <= rel_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  assign bus.domain_rst_n = rel_q;
  assign bus.ready        = ready_q;
  assign bus.busy         = busy_q;
  assign bus.cycle_count  = count_q;
  assign bus.limit_hit    = limit_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-on, sw reset, extended sw reset, mid-GAP abort, hold, limit.
// Pn below means the n-th posedge after rst_n rises (P0 first); samples are taken #1 after the edge.
// Inputs change only just after a posedge.
module tb_reset_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   chk_total = 0;
  int   chk_pass  = 0;

  reset_sequencer_if #(.NumDomains(4)) bus ();

  reset_sequencer #(
    .NumDomains    (4),
    .SyncStages    (2),
    .ReleaseGap    (2),
    .SwResetCycles (4),
    .MaxCycleCount (32'd16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_total++;
    if (obs === exp) begin
      chk_pass++;
    end else begin
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.sw_rst_req = 1'b0;
    bus.hold       = 1'b0;
    #2 rst_n = 1'b0;
    tick(2);
    check("rst_domain", 32'(bus.domain_rst_n), 32'h0);
    check("rst_ready",  32'(bus.ready), 32'd0);
    check("rst_busy",   32'(bus.busy), 32'd1);
    check("rst_count",  bus.cycle_count, 32'd0);
    check("rst_limit",  32'(bus.limit_hit), 32'd0);

    // Power-on sequence, T0 = P2.
    rst_n = 1'b1;
    tick(4);  // P3
    check("por_p3_dom", 32'(bus.domain_rst_n), 32'h0);
    tick(1);  // P4
    check("por_p4_dom", 32'(bus.domain_rst_n), 32'h1);
    tick(1);  // P5
    check("por_p5_dom", 32'(bus.domain_rst_n), 32'h1);
    tick(1);  // P6
    check("por_p6_dom", 32'(bus.domain_rst_n), 32'h3);
    tick(2);  // P8
    check("por_p8_dom", 32'(bus.domain_rst_n), 32'h7);
    tick(2);  // P10
    check("por_p10_dom",   32'(bus.domain_rst_n), 32'hF);
    check("por_p10_ready", 32'(bus.ready), 32'd0);
    tick(1);  // P11
    check("por_p11_ready", 32'(bus.ready), 32'd1);
    check("por_p11_busy",  32'(bus.busy), 32'd0);
    check("por_p11_count", bus.cycle_count, 32'd10);
    tick(5);  // P16
    check("lim_p16_count", bus.cycle_count, 32'd15);
    check("lim_p16_limit", 32'(bus.limit_hit), 32'd0);
    tick(1);  // P17
    check("lim_p17_count", bus.cycle_count, 32'd16);
    check("lim_p17_limit", 32'(bus.limit_hit), 32'd1);

    // Software reset from RUN, request sampled at P18, new T0 = P22.
    bus.sw_rst_req = 1'b1;
    tick(1);  // P18
    bus.sw_rst_req = 1'b0;
    check("sw_p18_dom",   32'(bus.domain_rst_n), 32'h0);
    check("sw_p18_ready", 32'(bus.ready), 32'd0);
    check("sw_p18_busy",  32'(bus.busy), 32'd1);
    tick(5);  // P23
    check("sw_p23_dom", 32'(bus.domain_rst_n), 32'h0);
    tick(1);  // P24
    check("sw_p24_dom", 32'(bus.domain_rst_n), 32'h1);
    tick(6);  // P30
    check("sw_p30_dom", 32'(bus.domain_rst_n), 32'hF);
    tick(1);  // P31
    check("sw_p31_ready", 32'(bus.ready), 32'd1);
    check("sw_p31_count", bus.cycle_count, 32'd30);
    check("sw_p31_limit", 32'(bus.limit_hit), 32'd1);

    // Request at P32, repeated at P34: window ends at P38 instead of P36.
    bus.sw_rst_req = 1'b1;
    tick(1);  // P32
    bus.sw_rst_req = 1'b0;
    tick(1);  // P33
    bus.sw_rst_req = 1'b1;
    tick(1);  // P34
    bus.sw_rst_req = 1'b0;
    tick(4);  // P38
    check("ext_p38_dom",  32'(bus.domain_rst_n), 32'h0);
    check("ext_p38_busy", 32'(bus.busy), 32'd1);
    tick(2);  // P40
    check("ext_p40_dom", 32'(bus.domain_rst_n), 32'h1);
    tick(2);  // P42
    check("ext_p42_dom", 32'(bus.domain_rst_n), 32'h3);

    // Async abort mid-GAP.
    rst_n = 1'b0;
    #1;
    check("abort_dom",   32'(bus.domain_rst_n), 32'h0);
    check("abort_ready", 32'(bus.ready), 32'd0);
    check("abort_busy",  32'(bus.busy), 32'd1);
    check("abort_count", bus.cycle_count, 32'd0);
    check("abort_limit", 32'(bus.limit_hit), 32'd0);

    // Re-sequence with hold=1 through P20; a sw request in SYNC at P5 must be ignored.
    bus.hold = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(5);  // P4
    bus.sw_rst_req = 1'b1;
    tick(1);  // P5
    bus.sw_rst_req = 1'b0;
    tick(15); // P20
    check("hold_p20_dom",   32'(bus.domain_rst_n), 32'h0);
    check("hold_p20_busy",  32'(bus.busy), 32'd1);
    check("hold_p20_count", bus.cycle_count, 32'd0);
    bus.hold = 1'b0;
    tick(1);  // P21 = T0
    check("hold_p21_count", bus.cycle_count, 32'd1);
    check("hold_p21_dom",   32'(bus.domain_rst_n), 32'h0);
    tick(1);  // P22
    check("hold_p22_dom", 32'(bus.domain_rst_n), 32'h0);
    tick(1);  // P23
    check("hold_p23_dom", 32'(bus.domain_rst_n), 32'h1);
    tick(6);  // P29
    check("hold_p29_dom",   32'(bus.domain_rst_n), 32'hF);
    check("hold_p29_ready", 32'(bus.ready), 32'd0);
    tick(1);  // P30
    check("hold_p30_ready", 32'(bus.ready), 32'd1);
    check("hold_p30_count", bus.cycle_count, 32'd10);
    check("hold_p30_limit", 32'(bus.limit_hit), 32'd0);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
